// File: rtl/vtg_pkg.sv
// Shared timing constants (640x480@60), derived totals and region encoding for video_timing_gen.
// Optional VTG_PIXEL_INDEX_EN adds a linear pixel index output to the top.
package vtg_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam logic VGA_HS_POL = 1'b0;
  localparam logic VGA_VS_POL = 1'b0;

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FP,
    REG_SYNC,
    REG_BP
  } region_e;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// Wrap counter for one video axis: terminal flag on the last position and a
// decode of which region (active/front porch/sync/back porch) the count sits in.
module vtg_axis_counter
  import vtg_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP,
  parameter int unsigned W      = cnt_width(ACTIVE + FP + SYNC + BP)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_adv,
  output logic [W-1:0] o_count,
  output logic         o_last,
  output region_e      o_region
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [31:0] pos;

  assign o_last = (o_count == LAST);
  assign pos    = 32'(o_count);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_count <= '0;
    end else if (i_adv) begin
      o_count <= o_last ? '0 : o_count + 1'b1;
    end
  end

  always_comb begin
    o_region = REG_BP;
    if (pos < ACTIVE) begin
      o_region = REG_ACTIVE;
    end else if (pos < ACTIVE + FP) begin
      o_region = REG_FP;
    end else if (pos < ACTIVE + FP + SYNC) begin
      o_region = REG_SYNC;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters with registered sync, blank and position outputs.
// Define VTG_PIXEL_INDEX_EN to add o_pixel_index (linear v*H_TOTAL+h position).
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter logic        HS_POL   = VGA_HS_POL,
  parameter logic        VS_POL   = VGA_VS_POL,
  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned XW      = cnt_width(H_TOTAL),
  localparam int unsigned YW      = cnt_width(V_TOTAL)
`ifdef VTG_PIXEL_INDEX_EN
  , localparam int unsigned PW    = cnt_width(H_TOTAL * V_TOTAL)
`endif
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_blank,
  output logic          o_de,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start
`ifdef VTG_PIXEL_INDEX_EN
  , output logic [PW-1:0] o_pixel_index
`endif
);

  logic [XW-1:0] h;
  logic [YW-1:0] v;
  logic          h_last;
  region_e       h_reg;
  region_e       v_reg;
  logic          active;
`ifdef VTG_PIXEL_INDEX_EN
  logic          v_last;
`else
  logic          v_last_unused;
`endif

  vtg_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (XW)
  ) u_h_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_adv    (i_en),
    .o_count  (h),
    .o_last   (h_last),
    .o_region (h_reg)
  );

  vtg_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (YW)
  ) u_v_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_adv    (i_en & h_last),
`ifdef VTG_PIXEL_INDEX_EN
    .o_last   (v_last),
`else
    .o_last   (v_last_unused),
`endif
    .o_count  (v),
    .o_region (v_reg)
  );

  assign active = (h_reg == REG_ACTIVE) && (v_reg == REG_ACTIVE);

  // Outputs decode the counters' pre-advance value, so pins trail the counters by one enabled edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_hsync       <= ~HS_POL;
      o_vsync       <= ~VS_POL;
      o_blank       <= 1'b1;
      o_de          <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else if (i_en) begin
      o_hsync       <= (h_reg == REG_SYNC) ? HS_POL : ~HS_POL;
      o_vsync       <= (v_reg == REG_SYNC) ? VS_POL : ~VS_POL;
      o_blank       <= ~active;
      o_de          <= active;
      o_x           <= h;
      o_y           <= v;
      o_line_start  <= (h == '0);
      o_frame_start <= (h == '0) && (v == '0);
    end else begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end
  end

`ifdef VTG_PIXEL_INDEX_EN
  logic [PW-1:0] pidx;

  // Tracks v*H_TOTAL+h by counting, wrapping on the same edge the v counter wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pidx          <= '0;
      o_pixel_index <= '0;
    end else if (i_en) begin
      pidx          <= (h_last && v_last) ? '0 : pidx + 1'b1;
      o_pixel_index <= pidx;
    end
  end
`endif

endmodule
